jacobi_sym_loader: RTL and testbench
====================================

# jacobi_sym_loader

Input staging stage directly upstream of `jacobi_top`. Accepts the upper triangle (diagonal included) of a symmetric N×N matrix as a row-major word stream, stores it, then replays the full N×N matrix row-major, mirroring the lower triangle. Only N(N+1)/2 words cross the host interface, while the Jacobi core receives N² words on its valid/ready input. The loader is single-buffered: it loads one frame, then emits that frame.

## Interface
- `N`, 8: matrix dimension; legal range is 2..16.
- `WORD_WIDTH`, 16: word width; equals the core's `IN_WORD_WIDTH`.
- `clk` in 1: single clock domain; all logic is on its rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_dat_i` in WORD_WIDTH: upper-triangle element.
- `in_vld_i` in 1: input valid.
- `in_rdy_o` out 1: input ready.
- `out_dat_o` out WORD_WIDTH: matrix element; connects to the core's `in_dat_i`.
- `out_vld_o` out 1: output valid.
- `out_rdy_i` in 1: output ready; connects to the core's `in_rdy_o`.
- `in_last_i` in 1: marks the final input word of a frame. Present only with `JACOBI_LOADER_CHK_EN`.
- `err_o` out 1: frame length error pulse. Present only with `JACOBI_LOADER_CHK_EN`.

## Operation
- **Constants**
  - T = N(N+1)/2 is the input count.
  - M = N² is the output count.
- **Storage**
  - T registers of WORD_WIDTH, indexed by triangle index idx(i,j) = i·N − i(i−1)/2 + (j−i), for i ≤ j.
  - Storage is not reset.
- **States**
  - LOAD: `in_rdy_o`=1, `out_vld_o`=0.
  - EMIT: `in_rdy_o`=0, `out_vld_o`=1.
- **LOAD**
  - Each accept (`in_vld_i`&`in_rdy_o`) writes word k to register k, then increments the write counter `wcnt`.
  - The accept with `wcnt`=T−1 clears `wcnt` and moves to EMIT.
- **EMIT**
  - Row counter r and column counter c, each 0..N−1, start at 0.
  - `out_dat_o` is a combinational read: reg[idx(r,c)] when r ≤ c, otherwise reg[idx(c,r)].
  - Each output accept (`out_vld_o`&`out_rdy_i`) advances c; when c wraps from N−1 to 0, r increments.
  - The accept at (N−1,N−1) clears r and c and moves to LOAD.
- **Backpressure**
  - `out_rdy_i`=0 holds r, c and `out_dat_o` stable.
  - `out_vld_o` is never withdrawn before it is accepted.
- **Counter widths**: `wcnt` is $clog2(T) bits; r and c are $clog2(N) bits each, with explicit wrap compares rather than reliance on overflow.
- **Ordering**: no overlap between frames. The next frame's first word is accepted no earlier than the cycle after the last emit accept.

## Timing
- **Reset values**
  - State=LOAD; `wcnt`, r and c = 0.
  - `in_rdy_o`=1, `out_vld_o`=0, `err_o`=0.
  - `out_dat_o` is don't-care while `out_vld_o`=0.
- **Latency**: first `out_vld_o` is high in the cycle after the T-th input accept.
- **Throughput**
  - Input side: one word per cycle.
  - Output side: one word per cycle while `out_rdy_i`=1.
  - Frame period: T+M cycles minimum.
- **Reset mid-frame**: all counters return to 0 and state returns to LOAD immediately, with no partial output. `out_vld_o` drops asynchronously.
- **Ignored input**: `in_vld_i` during EMIT is ignored; data is not consumed and the upstream must hold it.

## Configuration
- **Macro**: `JACOBI_LOADER_CHK_EN`.
- **With the macro**
  - `in_last_i` is sampled on every input accept.
  - Error condition: `in_last_i`=1 while `wcnt` < T−1, or `in_last_i`=0 while `wcnt`=T−1.
  - On error: `err_o` pulses high for exactly one cycle after the offending accept; `wcnt` clears; the state remains LOAD; the frame is discarded and nothing is emitted.
  - `err_o` is registered.
- **Without the macro**: neither port exists, and frames are delimited purely by count.

## Structure
- **Package `jacobi_pkg`**
  - Holds the default N and WORD_WIDTH, the T and M localparam functions, the state enum `loader_state_t` {LOAD, EMIT}, and the function `tri_idx(i,j,N)`.
  - The package is shared with `jacobi_top`.
- **Sub-module `jacobi_tri_store`**: the T-entry register file, with a write port and the mirrored combinational read at (r,c). The controller stays in `jacobi_sym_loader`.

## Test plan
Scenarios 1–4 and 6 use N=4 (T=10, M=16).
1. **Basic mirror**
   - Stimulus: inputs 1..10.
   - Required output: 1 2 3 4 / 2 5 6 7 / 3 6 8 9 / 4 7 9 10, then `in_rdy_o`=1 again.
2. **Output backpressure**
   - Stimulus: `out_rdy_i` toggles 1,0,0,1 throughout.
   - Required: same 16-word sequence; data stable while stalled; no word dropped or repeated.
3. **Input bubbles and back-to-back frames**
   - Stimulus: random `in_vld_i` gaps; frame A (1..10) then frame B (101..110) presented immediately.
   - Required: B is not accepted until A's 16th word is taken; B is emitted correctly.
4. **Mid-frame reset**
   - Stimulus: `rst` low during the 7th emit.
   - Required: `out_vld_o`=0 at once; after release a new frame 11..20 emits from 11.
5. **Default size**
   - Stimulus: N=8, inputs 0..35.
   - Required: output (7,0)=7 and (7,7)=35; 64 words total.
6. **CHK_EN**
   - Stimulus: `in_last_i` on word 8.
   - Required: one-cycle `err_o` pulse, no output.
   - Follow-up: a correct 10-word frame with last on word 10 then emits normally.

Source files
------------

// File: rtl/jacobi_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jacobi_pkg
// Purpose  : Shared constants, state type and triangle-index helper for the
//            Jacobi input loader and the Jacobi core.
// Revision : 1.0 - initial release
// ============================================================================
package jacobi_pkg;

  localparam int N_DEFAULT          = 8;
  localparam int WORD_WIDTH_DEFAULT = 16;

  typedef enum logic [0:0] {
    LOAD = 1'b0,
    EMIT = 1'b1
  } loader_state_t;

  // Number of upper-triangle words (diagonal included) in an n x n matrix.
  function automatic int tri_count(input int n);
    return (n * (n + 1)) / 2;
  endfunction

  // Number of words in the full n x n matrix.
  function automatic int mat_count(input int n);
    return n * n;
  endfunction

  // Row-major position of element (i,j), i <= j, within the packed upper triangle.
  function automatic int tri_idx(input int i, input int j, input int n);
    return (i * n) - ((i * (i - 1)) / 2) + (j - i);
  endfunction

endpackage
`default_nettype wire

// File: rtl/jacobi_sym_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : jacobi_sym_loader_if
// Purpose  : Host-side and core-side valid/ready channels of the symmetric
//            matrix loader. in_last_i / err_o exist only when
//            JACOBI_LOADER_CHK_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
interface jacobi_sym_loader_if #(
  parameter int WORD_WIDTH = 16
);

  logic [WORD_WIDTH-1:0] in_dat_i;
  logic                  in_vld_i;
  logic                  in_rdy_o;
  logic [WORD_WIDTH-1:0] out_dat_o;
  logic                  out_vld_o;
  logic                  out_rdy_i;
`ifdef JACOBI_LOADER_CHK_EN
  logic                  in_last_i;
  logic                  err_o;
`endif

`ifdef JACOBI_LOADER_CHK_EN
  modport slave (
    input  in_dat_i, in_vld_i, in_last_i, out_rdy_i,
    output in_rdy_o, out_dat_o, out_vld_o, err_o
  );
  modport master (
    output in_dat_i, in_vld_i, in_last_i, out_rdy_i,
    input  in_rdy_o, out_dat_o, out_vld_o, err_o
  );
`else
  modport slave (
    input  in_dat_i, in_vld_i, out_rdy_i,
    output in_rdy_o, out_dat_o, out_vld_o
  );
  modport master (
    output in_dat_i, in_vld_i, out_rdy_i,
    input  in_rdy_o, out_dat_o, out_vld_o
  );
`endif

endinterface
`default_nettype wire

// File: rtl/jacobi_tri_store.sv
`default_nettype none
// ============================================================================
// Module   : jacobi_tri_store
// Purpose  : T-entry register file holding the packed upper triangle. One
//            write port; one combinational read port addressed by (row,col)
//            that mirrors the lower triangle onto the stored upper triangle.
// Revision : 1.0 - initial release
// ============================================================================
module jacobi_tri_store
  import jacobi_pkg::*;
#(
  parameter int  N          = N_DEFAULT,
  parameter int  WORD_WIDTH = WORD_WIDTH_DEFAULT,
  localparam int T          = tri_count(N),
  localparam int AW         = $clog2(T),
  localparam int RW         = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [WORD_WIDTH-1:0] wr_dat,
  input  logic [RW-1:0]         rd_row,
  input  logic [RW-1:0]         rd_col,
  output logic [WORD_WIDTH-1:0] rd_dat
);

  // Contents are always fully rewritten before being read, so no reset.
  logic [WORD_WIDTH-1:0] r_mem [T];
  logic [AW-1:0]         w_rd_idx;

  // Store one upper-triangle word per accepted input.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_dat;
    end
  end

  // Below the diagonal, swap the coordinates to hit the mirrored element.
  always_comb begin
    w_rd_idx = '0;
    if (rd_row <= rd_col) begin
      w_rd_idx = AW'(tri_idx(int'(rd_row), int'(rd_col), N));
    end else begin
      w_rd_idx = AW'(tri_idx(int'(rd_col), int'(rd_row), N));
    end
  end

  assign rd_dat = r_mem[w_rd_idx];

endmodule
`default_nettype wire

// File: rtl/jacobi_sym_loader.sv
`default_nettype none
// ============================================================================
// Module   : jacobi_sym_loader
// Purpose  : Single-buffered staging stage ahead of jacobi_top. Loads the
//            upper triangle of a symmetric N x N matrix (T words), then
//            replays the full matrix row-major (N*N words).
//            Optional macro JACOBI_LOADER_CHK_EN adds in_last_i framing
//            check with a registered one-cycle err_o pulse.
// Revision : 1.0 - initial release
// ============================================================================
module jacobi_sym_loader
  import jacobi_pkg::*;
#(
  parameter int  N          = N_DEFAULT,
  parameter int  WORD_WIDTH = WORD_WIDTH_DEFAULT,
  localparam int T          = tri_count(N),
  localparam int WW         = $clog2(T),
  localparam int RW         = $clog2(N)
) (
  input logic                clk,
  input logic                rst,
  jacobi_sym_loader_if.slave bus
);

  localparam logic [WW-1:0] WCNT_LAST = WW'(T - 1);
  localparam logic [RW-1:0] IDX_LAST  = RW'(N - 1);

  loader_state_t r_state;
  loader_state_t w_state_nxt;
  logic [WW-1:0] r_wcnt;
  logic [WW-1:0] w_wcnt_nxt;
  logic [RW-1:0] r_row;
  logic [RW-1:0] w_row_nxt;
  logic [RW-1:0] r_col;
  logic [RW-1:0] w_col_nxt;
  logic          w_in_rdy;
  logic          w_out_vld;
  logic          w_in_acc;
  logic          w_out_acc;
  logic          w_wcnt_last;
  logic          w_len_err;

  assign w_in_rdy    = (r_state == LOAD);
  assign w_out_vld   = (r_state == EMIT);
  assign w_in_acc    = bus.in_vld_i & w_in_rdy;
  assign w_out_acc   = w_out_vld & bus.out_rdy_i;
  assign w_wcnt_last = (r_wcnt == WCNT_LAST);

  assign bus.in_rdy_o  = w_in_rdy;
  assign bus.out_vld_o = w_out_vld;

`ifdef JACOBI_LOADER_CHK_EN
  logic r_err;

  // Last flag must coincide exactly with the T-th word of the frame.
  assign w_len_err = w_in_acc & (bus.in_last_i ^ w_wcnt_last);

  // Registered error pulse, high for the cycle after the offending accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_len_err;
    end
  end

  assign bus.err_o = r_err;
`else
  assign w_len_err = 1'b0;
`endif

  // Controller state and counters; reset returns to an empty LOAD at once.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= LOAD;
      r_wcnt  <= '0;
      r_row   <= '0;
      r_col   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
    end
  end

  // Next-state: count in T words, then walk (row,col) over the full matrix.
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    case (r_state)
      LOAD: begin
        if (w_in_acc) begin
          if (w_len_err) begin
            // Malformed frame: drop it and start a fresh load.
            w_wcnt_nxt = '0;
          end else if (w_wcnt_last) begin
            w_wcnt_nxt  = '0;
            w_state_nxt = EMIT;
          end else begin
            w_wcnt_nxt = r_wcnt + 1'b1;
          end
        end
      end
      EMIT: begin
        if (w_out_acc) begin
          if (r_col == IDX_LAST) begin
            w_col_nxt = '0;
            if (r_row == IDX_LAST) begin
              w_row_nxt   = '0;
              w_state_nxt = LOAD;
            end else begin
              w_row_nxt = r_row + 1'b1;
            end
          end else begin
            w_col_nxt = r_col + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = LOAD;
      end
    endcase
  end

  jacobi_tri_store #(
    .N          (N),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_store (
    .clk     (clk),
    .wr_en   (w_in_acc),
    .wr_addr (r_wcnt),
    .wr_dat  (bus.in_dat_i),
    .rd_row  (r_row),
    .rd_col  (r_col),
    .rd_dat  (bus.out_dat_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_jacobi_sym_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_jacobi_sym_loader
// Purpose  : Self-checking bench for jacobi_sym_loader (N=4 and N=8 builds).
//            Reference model expands the upper triangle into a full
//            symmetric matrix; a monitor compares every output accept.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_jacobi_sym_loader;
  import jacobi_pkg::*;

  localparam int W = 16;
  typedef logic [W-1:0] word_t;
  typedef word_t wq_t[$];

  logic clk  = 1'b0;
  logic rst4 = 1'b1;
  logic rst8 = 1'b1;
  always #5 clk = ~clk;

  jacobi_sym_loader_if #(.WORD_WIDTH(W)) bus4 ();
  jacobi_sym_loader_if #(.WORD_WIDTH(W)) bus8 ();

  jacobi_sym_loader #(.N(4), .WORD_WIDTH(W)) dut4 (.clk(clk), .rst(rst4), .bus(bus4.slave));
  jacobi_sym_loader #(.N(8), .WORD_WIDTH(W)) dut8 (.clk(clk), .rst(rst8), .bus(bus8.slave));

  int    n_vec = 0;
  int    n_bad = 0;
  word_t exp4[$];
  word_t exp8[$];
  word_t got4[$];
  word_t got8[$];
  int    rdy_mode4 = 0;
  int    rdy_ph4   = 0;
  bit    hold_v4   = 0;
  bit    hold_v8   = 0;
  word_t hold_d4;
  word_t hold_d8;
  int    err_pulses4 = 0;
  int    mirror4[16] = '{1, 2, 3, 4, 2, 5, 6, 7, 3, 6, 8, 9, 4, 7, 9, 10};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic wq_t seq(input int start, input int n);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back(word_t'(start + i));
    return q;
  endfunction

  function automatic wq_t rnd(input int n);
    wq_t q;
    for (int i = 0; i < n; i++) q.push_back(word_t'($urandom));
    return q;
  endfunction

  // Reference: expand the upper triangle into a full symmetric matrix.
  task automatic expect_frame(input bit is8, input int n, input wq_t up);
    word_t a[16][16];
    int    k = 0;
    for (int i = 0; i < n; i++)
      for (int j = i; j < n; j++) begin
        a[i][j] = up[k];
        a[j][i] = up[k];
        k++;
      end
    for (int i = 0; i < n; i++)
      for (int j = 0; j < n; j++)
        if (is8) exp8.push_back(a[i][j]); else exp4.push_back(a[i][j]);
  endtask

  task automatic drive(input bit is8, input logic v, input word_t d, input logic l);
    if (is8) begin
      bus8.in_vld_i = v; bus8.in_dat_i = d;
`ifdef JACOBI_LOADER_CHK_EN
      bus8.in_last_i = l;
`endif
    end else begin
      bus4.in_vld_i = v; bus4.in_dat_i = d;
`ifdef JACOBI_LOADER_CHK_EN
      bus4.in_last_i = l;
`endif
    end
  endtask

  // Present words one by one; first word immediately, later ones after random bubbles.
  task automatic send(input bit is8, input wq_t up, input int last_at, input int max_gap);
    for (int k = 0; k < up.size(); k++) begin
      int gap;
      bit acc;
      int cyc;
      gap = (k > 0 && max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      repeat (gap) begin @(posedge clk); #1; end
      drive(is8, 1'b1, up[k], (k + 1) == last_at);
      cyc = 0;
      forever begin
        @(negedge clk);
        acc = is8 ? bus8.in_rdy_o : bus4.in_rdy_o;
        @(posedge clk); #1;
        if (acc) break;
        cyc++;
        if (cyc > 500) begin
          n_vec++; n_bad++;
          $display("FAIL in_accept_timeout: word %0d not accepted, expected accept within 500 cycles", k);
          break;
        end
      end
      drive(is8, 1'b0, '0, 1'b0);
    end
  endtask

  task automatic drain(input bit is8);
    int cyc = 0;
    while ((is8 ? exp8.size() : exp4.size()) != 0 || (is8 ? bus8.out_vld_o : bus4.out_vld_o)) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 3000) begin
        n_vec++; n_bad++;
        $display("FAIL drain_timeout: %0d words outstanding, expected 0", is8 ? exp8.size() : exp4.size());
        break;
      end
    end
  endtask

  // Output-ready pattern generators.
  always @(posedge clk) begin
    #1;
    case (rdy_mode4)
      0: bus4.out_rdy_i = 1'b1;
      1: begin
        bus4.out_rdy_i = (rdy_ph4 % 4 == 0) || (rdy_ph4 % 4 == 3);
        rdy_ph4++;
      end
      default: bus4.out_rdy_i = 1'($urandom_range(1, 0));
    endcase
    bus8.out_rdy_i = 1'($urandom_range(1, 0));
  end

  // Monitor N=4: scoreboard pop on accept, stability under stall, no frame overlap.
  always @(negedge clk) begin
    if (rst4 && bus4.out_vld_o) begin
      if (hold_v4) check("hold4", bus4.out_dat_o, hold_d4);
      if (bus4.out_rdy_i) begin
        if (exp4.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL out4_extra: got %0h, expected no output", bus4.out_dat_o);
        end else check("out4", bus4.out_dat_o, exp4.pop_front());
        got4.push_back(bus4.out_dat_o);
        hold_v4 = 0;
      end else begin
        hold_v4 = 1;
        hold_d4 = bus4.out_dat_o;
      end
    end else hold_v4 = 0;
    if (rst4 && bus4.in_vld_i && bus4.in_rdy_o) check("overlap4", exp4.size(), 0);
`ifdef JACOBI_LOADER_CHK_EN
    if (bus4.err_o === 1'b1) err_pulses4++;
`endif
  end

  // Monitor N=8.
  always @(negedge clk) begin
    if (rst8 && bus8.out_vld_o) begin
      if (hold_v8) check("hold8", bus8.out_dat_o, hold_d8);
      if (bus8.out_rdy_i) begin
        if (exp8.size() == 0) begin
          n_vec++; n_bad++;
          $display("FAIL out8_extra: got %0h, expected no output", bus8.out_dat_o);
        end else check("out8", bus8.out_dat_o, exp8.pop_front());
        got8.push_back(bus8.out_dat_o);
        hold_v8 = 0;
      end else begin
        hold_v8 = 1;
        hold_d8 = bus8.out_dat_o;
      end
    end else hold_v8 = 0;
    if (rst8 && bus8.in_vld_i && bus8.in_rdy_o) check("overlap8", exp8.size(), 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    wq_t fr;
    wq_t fb;
    int  base;
    int  cyc;
    drive(1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0);
    bus4.out_rdy_i = 1'b1;
    bus8.out_rdy_i = 1'b1;
    #2;
    rst4 = 1'b0;
    rst8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy4", bus4.in_rdy_o, 1);
    check("rst_out_vld4", bus4.out_vld_o, 0);
    check("rst_in_rdy8", bus8.in_rdy_o, 1);
    check("rst_out_vld8", bus8.out_vld_o, 0);
`ifdef JACOBI_LOADER_CHK_EN
    check("rst_err4", bus4.err_o, 0);
`endif
    rst4 = 1'b1;
    rst8 = 1'b1;
    @(posedge clk); #1;

    // Basic mirror.
    rdy_mode4 = 0;
    base = got4.size();
    fr = seq(1, 10);
    send(1'b0, fr, 10, 0);
    expect_frame(1'b0, 4, fr);
    drain(1'b0);
    for (int i = 0; i < 16; i++) check("mirror_basic", got4[base + i], mirror4[i]);
    check("in_rdy_after_frame", bus4.in_rdy_o, 1);

    // Output backpressure 1,0,0,1.
    rdy_mode4 = 1;
    base = got4.size();
    send(1'b0, fr, 10, 0);
    expect_frame(1'b0, 4, fr);
    drain(1'b0);
    check("bp_count", got4.size() - base, 16);
    for (int i = 0; i < 16; i++) check("mirror_bp", got4[base + i], mirror4[i]);

    // Input bubbles and back-to-back frames A then B.
    rdy_mode4 = 2;
    fr = seq(1, 10);
    fb = seq(101, 10);
    send(1'b0, fr, 10, 3);
    expect_frame(1'b0, 4, fr);
    send(1'b0, fb, 10, 3);
    expect_frame(1'b0, 4, fb);
    drain(1'b0);

    // Random frames with random gaps and random ready.
    for (int f = 0; f < 4; f++) begin
      fr = rnd(10);
      send(1'b0, fr, 10, 2);
      expect_frame(1'b0, 4, fr);
    end
    drain(1'b0);

    // Mid-frame reset during the 7th emit.
    rdy_mode4 = 0;
    base = got4.size();
    fr = seq(1, 10);
    send(1'b0, fr, 10, 0);
    expect_frame(1'b0, 4, fr);
    cyc = 0;
    while (got4.size() < base + 6 && cyc < 200) begin @(negedge clk); cyc++; end
    check("pre_reset_count", got4.size() - base, 6);
    @(posedge clk);
    #3;
    rst4 = 1'b0;
    #1;
    check("reset_out_vld", bus4.out_vld_o, 0);
    check("reset_in_rdy", bus4.in_rdy_o, 1);
    exp4.delete();
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1'b1;
    @(posedge clk); #1;
    base = got4.size();
    fr = seq(11, 10);
    send(1'b0, fr, 10, 0);
    expect_frame(1'b0, 4, fr);
    drain(1'b0);
    check("post_reset_first", got4[base], 11);
    check("post_reset_count", got4.size() - base, 16);

    // Default size N=8, inputs 0..35.
    base = got8.size();
    fr = seq(0, 36);
    send(1'b1, fr, 36, 1);
    expect_frame(1'b1, 8, fr);
    drain(1'b1);
    check("n8_count", got8.size() - base, 64);
    check("n8_elem_7_0", got8[base + 56], 7);
    check("n8_elem_7_7", got8[base + 63], 35);
    fr = rnd(36);
    send(1'b1, fr, 36, 1);
    expect_frame(1'b1, 8, fr);
    drain(1'b1);

`ifdef JACOBI_LOADER_CHK_EN
    // Early last flag on word 8: error pulse, frame dropped.
    rdy_mode4 = 0;
    base = got4.size();
    fr = seq(1, 8);
    send(1'b0, fr, 8, 0);
    check("err_pulse_high", bus4.err_o, 1);
    @(posedge clk); #1;
    check("err_pulse_low", bus4.err_o, 0);
    repeat (5) begin
      check("err_no_output", bus4.out_vld_o, 0);
      @(posedge clk); #1;
    end
    check("err_in_rdy", bus4.in_rdy_o, 1);
    fr = seq(1, 10);
    send(1'b0, fr, 10, 0);
    expect_frame(1'b0, 4, fr);
    drain(1'b0);
    for (int i = 0; i < 16; i++) check("mirror_after_err", got4[base + i], mirror4[i]);
    check("err_pulse_total", err_pulses4, 1);
`endif

    check("exp4_empty", exp4.size(), 0);
    check("exp8_empty", exp8.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
